// File: rtl/odd_count_arbiter.sv
// rtl/odd_count_arbiter.sv - arbitrated odd-step counter sweeps over a valid/ready beat stream
// Optional build macro: ODD_CNT_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module odd_count_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 7,
    parameter int START = 1,
    parameter int STEP  = 2,
    parameter int LIMIT = 101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] cnt_out,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             cnt_last,
    output logic             done,
    output logic             done_abort,
    output logic             busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Parameter sanity: the next-value sum must never wrap in WIDTH+1 bits.
    generate
        if (NREQ < 2) begin : g_chk_nreq
            $error("odd_count_arbiter: NREQ must be >= 2");
        end
        if (STEP <= 0) begin : g_chk_step
            $error("odd_count_arbiter: STEP must be > 0");
        end
        if (START > LIMIT) begin : g_chk_start
            $error("odd_count_arbiter: START must be <= LIMIT");
        end
        if (LIMIT + STEP >= (1 << (WIDTH + 1))) begin : g_chk_fit
            $error("odd_count_arbiter: LIMIT+STEP does not fit in WIDTH+1 bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    win;
    logic [IW-1:0]    win_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    rr_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             abort_q;
    logic             abort_nxt;
    logic [WIDTH:0]   sum;
    logic             at_last;
    logic             xfer;
    logic             found;
    logic [IW-1:0]    pick;
    logic [IW-1:0]    base;
    int               idx;

    // Next value in WIDTH+1 bits so the end-of-sweep test never sees a wrapped sum.
    always_comb begin
        sum     = {1'b0, cnt_out} + (WIDTH + 1)'(STEP);
        at_last = (sum > (WIDTH + 1)'(LIMIT));
    end

    // Winner search: first requester at or after the search base, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
`ifdef ODD_CNT_PRIO_EN
        base  = '0;
`else
        base  = rr_ptr;
`endif
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(base) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // Stream and status outputs decoded from the current state.
    always_comb begin
        gnt        = '0;
        cnt_valid  = (state == RUN);
        if (state == RUN) begin
            gnt[win] = 1'b1;
        end
        cnt_last   = cnt_valid & at_last;
        done       = (state == DONE);
        done_abort = done & abort_q;
        busy       = (state != IDLE);
        xfer       = cnt_valid & cnt_ready;
    end

    // Next-state logic: arbitrate in IDLE, step on transfers in RUN, one-cycle DONE.
    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        rr_nxt    = rr_ptr;
        cnt_nxt   = cnt_out;
        abort_nxt = abort_q;
        case (state)
            IDLE: begin
                abort_nxt = 1'b0;
                if (found) begin
                    state_nxt = RUN;
                    win_nxt   = pick;
                    cnt_nxt   = WIDTH'(START);
                end
            end
            RUN: begin
                // A dropped grant request ends the sweep even if a beat moves this cycle.
                if (!req[win]) begin
                    state_nxt = DONE;
                    abort_nxt = 1'b1;
                end else if (xfer) begin
                    if (at_last) begin
                        state_nxt = DONE;
                        abort_nxt = 1'b0;
                    end else begin
                        cnt_nxt = sum[WIDTH-1:0];
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                rr_nxt    = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win     <= '0;
            rr_ptr  <= '0;
            cnt_out <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            win     <= win_nxt;
            rr_ptr  <= rr_nxt;
            cnt_out <= cnt_nxt;
            abort_q <= abort_nxt;
        end
    end

endmodule
